fft_out_stream: RTL
===================

Name: fft_out_stream

Overview:
Output-side unloader for the FFT pipeline, the counterpart of the sample-input path driven by req_i/data_i.
- Triggered by the core's frame-complete pulse.
- Reads the N complex results from the result RAM, applies bit-reversed addressing when enabled, then applies a per-frame arithmetic scale.
- Streams the bins in natural order over a valid/ready interface with index and last markers.
- A 2-entry prefetch FIFO hides the RAM read latency and allows one bin per clock under no backpressure.

Parameters:
N, 64, FFT length in points (power of 2, ≥4).
LOG2N, 6, log2(N); address/index width.
DW, 16, sample width, signed Q15 for re and im.
BITREV, 1, 1 = rd_addr_o is the bit-reversed bin count; 0 = natural order.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
done_i  input  1  one-cycle pulse from the FFT core: result RAM holds a complete frame.
scale_i  input  4  arithmetic right-shift amount, sampled on accepted done_i.
busy_o  output  1  high from accepted done_i until the last beat is handshaken.
rd_en_o  output  1  result-RAM read strobe.
rd_addr_o  output  LOG2N  result-RAM read address.
rd_re_i  input  DW  RAM real data, valid the cycle after rd_en_o.
rd_im_i  input  DW  RAM imag data, valid the cycle after rd_en_o.
valid_o  output  1  output beat valid.
ready_i  input  1  downstream accepts the beat.
re_o  output  DW  scaled real part.
im_o  output  DW  scaled imaginary part.
index_o  output  LOG2N  natural-order bin index k of the current beat.
last_o  output  1  high with the beat where k = N-1.
frame_done_o  output  1  one-cycle pulse after the last beat's handshake.
overrun_o  output  1  sticky: done_i arrived while busy_o = 1.

Behaviour:
- Reset (async, any time, including mid-frame):
  - All outputs 0; FSM returns to IDLE.
  - FIFO is emptied, all counters are zeroed, the scale register is cleared, and overrun_o clears.
- FSM IDLE / READ / DRAIN:
  - IDLE: done_i=1 → latch scale_i, clear rd_cnt and index, busy_o=1, go to READ.
  - READ: issue reads. After the read with rd_cnt = N-1 is issued, go to DRAIN.
  - DRAIN: no reads. When the handshake with last_o=1 occurs → IDLE, busy_o=0, frame_done_o=1 for one cycle.
- Read issue: rd_en_o=1 in a cycle when state=READ and (fifo_count + inflight − pop) < 2, where pop = valid_o & ready_i.
  - rd_addr_o = BITREV ? bitrev(rd_cnt) : rd_cnt.
  - rd_cnt increments on each issue.
  - rd_en_o and rd_addr_o are combinational from registered state.
- Capture: the read data for a read issued in cycle t is written into the FIFO at the end of cycle t+1.
  - Data path: re/im → arithmetic shift right by the latched scale (sign-extended, truncating) → FIFO.
  - The shift result is always in range, so no saturation is needed.
- Output:
  - valid_o = FIFO non-empty; re_o/im_o = FIFO head.
  - index_o = count of beats already handshaken this frame; last_o = valid_o & (index_o == N-1).
- Backpressure:
  - While valid_o=1 and ready_i=0, re_o, im_o, index_o and last_o are held stable.
  - The FIFO never overflows; the credit rule guarantees this.
- Latency and throughput:
  - done_i in cycle 0 → rd_en_o first high in cycle 1, addr bitrev(0)=0 → valid_o first high in cycle 3.
  - With ready_i held high: one beat per cycle in cycles 3..N+2 and frame_done_o in cycle N+3.
- Simultaneous events:
  - done_i while busy_o=1 is ignored for control and sets overrun_o. The current frame completes unchanged.
  - done_i in the same cycle as frame_done_o is accepted and starts a new frame.
- Pop and push in the same cycle are both performed: count unchanged, FIFO order preserved.

Test Plan:
- N=8, BITREV=1, ready_i=1, RAM word[a] = {re=a·0x100, im=−a}, scale_i=0, done_i pulse in cycle 0 → rd_addr_o sequence 0,4,2,6,1,5,3,7 in cycles 1–8; valid_o in cycles 3–10 with re_o = 0x000,0x400,0x200,…; last_o only in cycle 10; frame_done_o in cycle 11.
- Same as above with BITREV=0 and scale_i=2, RAM re = 0x7FFF/0x8000 alternating → re_o = 0x1FFF / 0xE000, beat order 0..7, index_o = 0..7.
- ready_i toggled 1,0,0,1,… pseudo-randomly → no beat lost or duplicated; outputs stable while stalled; rd_en_o never issued when FIFO count plus in-flight reads would exceed 2.
- Second done_i mid-frame (cycle 5) → overrun_o=1 sticky; frame output is identical to the clean run. A third done_i coincident with frame_done_o → a second frame starts; first valid_o of that frame 3 cycles later.
- rst asserted mid-READ (after 3 beats), asynchronously between edges → all outputs 0 immediately; after release, a new done_i produces a full correct frame starting at index 0.

Source files
------------

// File: rtl/fft_out_stream_if.sv
// Output beat stream of the FFT unloader: one complex bin per handshake,
// tagged with its natural-order index and an end-of-frame marker.
interface fft_out_stream_if #(
    parameter int LOG2N = 6,
    parameter int DW    = 16
);
    logic                    valid;
    logic                    ready;
    logic signed [DW-1:0]    re;
    logic signed [DW-1:0]    im;
    logic        [LOG2N-1:0] index;
    logic                    last;

    modport master (output valid, re, im, index, last, input ready);
    modport slave  (input valid, re, im, index, last, output ready);
endinterface

// File: rtl/fft_out_stream.sv
// FFT result unloader: reads the result RAM (optionally bit-reversed), scales each
// bin by a per-frame arithmetic shift and streams bins in natural order.
module fft_out_stream #(
    parameter int N      = 64,
    parameter int LOG2N  = 6,
    parameter int DW     = 16,
    parameter int BITREV = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    done_i,
    input  logic [3:0]              scale_i,
    output logic                    busy_o,
    output logic                    rd_en_o,
    output logic [LOG2N-1:0]        rd_addr_o,
    input  logic signed [DW-1:0]    rd_re_i,
    input  logic signed [DW-1:0]    rd_im_i,
    output logic                    frame_done_o,
    output logic                    overrun_o,
    fft_out_stream_if.master        stream
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } bin_t;

    state_t           state;
    logic [LOG2N-1:0] rd_cnt;
    logic [LOG2N-1:0] index;
    logic [3:0]       scale;
    logic             inflight;
    bin_t             fifo [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             pop;
    logic             push;
    logic [2:0]       credit;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
        return r;
    endfunction

    assign pop    = stream.valid & stream.ready;
    assign push   = inflight;
    // Slots already claimed (stored + in flight); a beat leaving this cycle frees one.
    assign credit = {1'b0, count} + {2'b0, inflight};

    assign rd_en_o   = (state == READ) && (credit < 3'd2 + {2'b0, pop});
    assign rd_addr_o = (BITREV != 0) ? bitrev(rd_cnt) : rd_cnt;

    assign stream.valid = (count != 2'd0);
    assign stream.re    = fifo[rd_ptr].re;
    assign stream.im    = fifo[rd_ptr].im;
    assign stream.index = index;
    assign stream.last  = stream.valid && (index == LOG2N'(N-1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
            overrun_o    <= 1'b0;
            scale        <= '0;
            rd_cnt       <= '0;
            index        <= '0;
        end else begin
            frame_done_o <= 1'b0;
            if (done_i && busy_o) overrun_o <= 1'b1;
            if (rd_en_o) rd_cnt <= rd_cnt + 1'b1;
            if (pop)     index  <= index + 1'b1;
            case (state)
                IDLE: if (done_i) begin
                    scale  <= scale_i;
                    rd_cnt <= '0;
                    index  <= '0;
                    busy_o <= 1'b1;
                    state  <= READ;
                end
                READ: if (rd_en_o && rd_cnt == LOG2N'(N-1)) state <= DRAIN;
                DRAIN: if (pop && stream.last) begin
                    state        <= IDLE;
                    busy_o       <= 1'b0;
                    frame_done_o <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read data lands one cycle after the strobe and is scaled on the way in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo[0]  <= '0;
            fifo[1]  <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= rd_en_o;
            if (push) begin
                fifo[wr_ptr] <= '{re: rd_re_i >>> scale, im: rd_im_i >>> scale};
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule
